// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types and helpers for the multi-cycle ALU (alu_mc).
//   alu_op_t     5-bit opcode encoding (RV32I base ALU ops + RV32M ops)
//   alu_state_t  control FSM states
//   is_mul_op / is_div_op     opcode class decoders
//   is_signed_a / is_signed_b operand signedness for the M-extension ops
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'b00000,
        OP_SUB    = 5'b00001,
        OP_SLL    = 5'b00010,
        OP_SLT    = 5'b00011,
        OP_SLTU   = 5'b00100,
        OP_XOR    = 5'b00101,
        OP_SRL    = 5'b00110,
        OP_SRA    = 5'b00111,
        OP_OR     = 5'b01000,
        OP_AND    = 5'b01001,
        OP_MUL    = 5'b01010,
        OP_MULH   = 5'b01011,
        OP_MULHSU = 5'b01100,
        OP_MULHU  = 5'b01101,
        OP_DIV    = 5'b01110,
        OP_DIVU   = 5'b01111,
        OP_REM    = 5'b10000,
        OP_REMU   = 5'b10001
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } alu_state_t;

    function automatic logic is_mul_op(input alu_op_t op);
        case (op)
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(input alu_op_t op);
        case (op)
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    // Operand A is treated as two's complement for these ops.
    function automatic logic is_signed_a(input alu_op_t op);
        case (op)
            OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

    // Operand B is treated as two's complement for these ops.
    function automatic logic is_signed_b(input alu_op_t op);
        case (op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_iter_core.sv
// ---------------------------------------------------------------------------
// alu_iter_core
// Iterative multiply (shift-add) / restoring-divide engine working on operand
// magnitudes, with sign fixup applied on the final step.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        load operands and begin an XLEN-step operation
//   abort        drop the operation in flight
//   op           opcode (sampled with start)
//   a, b         operands (sampled with start)
//   done         final step is being taken this cycle; result is valid
//   result       final, sign-corrected result (valid while done)
// ---------------------------------------------------------------------------
module alu_iter_core
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  alu_op_t          op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    output logic             done,
    output logic [XLEN-1:0]  result
);

    // Multiply: hi_r/lo_r form the running 2*XLEN product, lo_r starts as the
    // multiplier and opnd_r holds the multiplicand.
    // Divide:   hi_r is the partial remainder, lo_r shifts the dividend out and
    // the quotient in, opnd_r holds the divisor.
    logic             active_r;
    logic [CNT_W-1:0] cnt_r;
    logic [XLEN-1:0]  hi_r;
    logic [XLEN-1:0]  lo_r;
    logic [XLEN-1:0]  opnd_r;
    logic             neg_q_r;
    logic             neg_rem_r;
    alu_op_t          op_r;

    logic             a_neg_s;
    logic             b_neg_s;
    logic [XLEN-1:0]  a_mag_s;
    logic [XLEN-1:0]  b_mag_s;
    logic [XLEN:0]    mul_sum_s;
    logic [XLEN:0]    div_sh_s;
    logic [XLEN:0]    div_diff_s;
    logic             div_ok_s;
    logic [XLEN-1:0]  hi_s;
    logic [XLEN-1:0]  lo_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]  quot_s;
    logic [XLEN-1:0]  rem_s;

    assign a_neg_s = is_signed_a(op) & a[XLEN-1];
    assign b_neg_s = is_signed_b(op) & b[XLEN-1];
    assign a_mag_s = a_neg_s ? ({XLEN{1'b0}} - a) : a;
    assign b_mag_s = b_neg_s ? ({XLEN{1'b0}} - b) : b;

    // One iteration of the selected algorithm on the current accumulators.
    always_comb begin
        mul_sum_s  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
        div_sh_s   = {hi_r, lo_r[XLEN-1]};
        div_ok_s   = (div_sh_s >= {1'b0, opnd_r});
        div_diff_s = div_sh_s - {1'b0, opnd_r};
        if (is_div_op(op_r)) begin
            hi_s = div_ok_s ? div_diff_s[XLEN-1:0] : div_sh_s[XLEN-1:0];
            lo_s = {lo_r[XLEN-2:0], div_ok_s};
        end else begin
            hi_s = mul_sum_s[XLEN:1];
            lo_s = {mul_sum_s[0], lo_r[XLEN-1:1]};
        end
    end

    // Sign fixup and result selection on the post-step accumulators, so the
    // result can be registered on the same edge as the last iteration.
    always_comb begin
        prod_s = neg_q_r ? ({(2*XLEN){1'b0}} - {hi_s, lo_s}) : {hi_s, lo_s};
        quot_s = neg_q_r ? ({XLEN{1'b0}} - lo_s) : lo_s;
        rem_s  = neg_rem_r ? ({XLEN{1'b0}} - hi_s) : hi_s;
        case (op_r)
            OP_MUL:                        result = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  result = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               result = quot_s;
            OP_REM, OP_REMU:               result = rem_s;
            default:                       result = {XLEN{1'b0}};
        endcase
    end

    assign done = active_r & (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1});

    // Operand load, iteration and counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_r  <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            hi_r      <= {XLEN{1'b0}};
            lo_r      <= {XLEN{1'b0}};
            opnd_r    <= {XLEN{1'b0}};
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
            op_r      <= OP_ADD;
        end else if (start) begin
            active_r  <= 1'b1;
            cnt_r     <= CNT_W'(XLEN);
            hi_r      <= {XLEN{1'b0}};
            op_r      <= op;
            neg_rem_r <= a_neg_s;
            if (is_div_op(op)) begin
                lo_r    <= a_mag_s;
                opnd_r  <= b_mag_s;
                // A zero divisor must yield an all-ones quotient, so the
                // quotient is never negated; the remainder naturally equals a.
                neg_q_r <= (a_neg_s ^ b_neg_s) & (b != {XLEN{1'b0}});
            end else begin
                lo_r    <= b_mag_s;
                opnd_r  <= a_mag_s;
                neg_q_r <= a_neg_s ^ b_neg_s;
            end
        end else if (abort) begin
            active_r <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
        end else if (active_r) begin
            hi_r     <= hi_s;
            lo_r     <= lo_s;
            cnt_r    <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            active_r <= ~done;
        end else begin
            active_r <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc
// Multi-cycle RV32I/RV32M ALU behind valid/ready handshakes. Base ops finish
// one cycle after acceptance; multiply/divide ops run in alu_iter_core.
// Optional build macro: ALU_DIV_SHORTCUT_EN -- divide-by-zero and signed
// overflow divides complete directly from IDLE (1-cycle latency).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake (in_ready = state is IDLE)
//   src_a, src_b        operands
//   alu_control         opcode (alu_op_t encoding)
//   flush               abort the in-flight op and drop its result
//   out_valid/out_ready result handshake
//   alu_result, zero    registered result and (result == 0)
// ---------------------------------------------------------------------------
module alu_mc
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [4:0]      alu_control,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result,
    output logic            zero
);

    localparam int SH_W = $clog2(XLEN);

    alu_state_t      state_r;
    alu_state_t      state_s;
    alu_op_t         op_s;
    logic            accept_s;
    logic [SH_W-1:0] shamt_s;
    logic [XLEN-1:0] base_s;
    logic            load_s;
    logic [XLEN-1:0] result_s;
    logic            core_start_s;
    logic            core_abort_s;
    logic            core_done_s;
    logic [XLEN-1:0] core_result_s;
    logic            out_valid_r;
    logic [XLEN-1:0] result_r;
    logic            zero_r;

    assign op_s     = alu_op_t'(alu_control);
    assign in_ready = (state_r == ST_IDLE);
    assign accept_s = in_valid & in_ready;
    assign shamt_s  = src_b[SH_W-1:0];

    // Single-cycle base operations; unknown codes give 0.
    always_comb begin
        case (op_s)
            OP_ADD:  base_s = src_a + src_b;
            OP_SUB:  base_s = src_a - src_b;
            OP_SLL:  base_s = src_a << shamt_s;
            OP_SLT:  base_s = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLTU: base_s = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            OP_XOR:  base_s = src_a ^ src_b;
            OP_SRL:  base_s = src_a >> shamt_s;
            OP_SRA:  base_s = $unsigned($signed(src_a) >>> shamt_s);
            OP_OR:   base_s = src_a | src_b;
            OP_AND:  base_s = src_a & src_b;
            default: base_s = {XLEN{1'b0}};
        endcase
    end

`ifdef ALU_DIV_SHORTCUT_EN
    logic            div_zero_s;
    logic            div_ovf_s;
    logic [XLEN-1:0] special_s;

    assign div_zero_s = (src_b == {XLEN{1'b0}});
    assign div_ovf_s  = is_signed_a(op_s) &&
                        (src_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                        (src_b == {XLEN{1'b1}});

    // Architectural results of the divide corner cases.
    always_comb begin
        if ((op_s == OP_DIV) || (op_s == OP_DIVU)) begin
            special_s = div_zero_s ? {XLEN{1'b1}} : src_a;
        end else begin
            special_s = div_zero_s ? src_a : {XLEN{1'b0}};
        end
    end
`endif

    alu_iter_core #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (core_start_s),
        .abort  (core_abort_s),
        .op     (op_s),
        .a      (src_a),
        .b      (src_b),
        .done   (core_done_s),
        .result (core_result_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, core control and result-load decisions (flush beats handshake).
    always_comb begin
        state_s      = state_r;
        load_s       = 1'b0;
        result_s     = {XLEN{1'b0}};
        core_start_s = 1'b0;
        core_abort_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (is_mul_op(op_s)) begin
                        core_start_s = 1'b1;
                        state_s      = ST_MUL;
                    end else if (is_div_op(op_s)) begin
`ifdef ALU_DIV_SHORTCUT_EN
                        if (div_zero_s || div_ovf_s) begin
                            load_s   = 1'b1;
                            result_s = special_s;
                            state_s  = ST_DONE;
                        end else begin
                            core_start_s = 1'b1;
                            state_s      = ST_DIV;
                        end
`else
                        core_start_s = 1'b1;
                        state_s      = ST_DIV;
`endif
                    end else begin
                        load_s   = 1'b1;
                        result_s = base_s;
                        state_s  = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (flush) begin
                    core_abort_s = 1'b1;
                    state_s      = ST_IDLE;
                end else if (core_done_s) begin
                    load_s   = 1'b1;
                    result_s = core_result_s;
                    state_s  = ST_DONE;
                end else begin
                    state_s = state_r;
                end
            end
            ST_DONE: begin
                if (flush || out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output registers: result and zero only change when a result is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            result_r    <= {XLEN{1'b0}};
            zero_r      <= 1'b1;
        end else begin
            out_valid_r <= (state_s == ST_DONE);
            if (load_s) begin
                result_r <= result_s;
                zero_r   <= (result_s == {XLEN{1'b0}});
            end else begin
                result_r <= result_r;
                zero_r   <= zero_r;
            end
        end
    end

    assign out_valid  = out_valid_r;
    assign alu_result = result_r;
    assign zero       = zero_r;

endmodule

// File: tb/tb_alu_mc.sv
// ---------------------------------------------------------------------------
// tb_alu_mc
// Table-driven directed test of alu_mc (XLEN=32) plus hand-written sequences
// for result hold, flush and mid-operation reset.
// ---------------------------------------------------------------------------
module tb_alu_mc;

    localparam int XLEN = 32;
`ifdef ALU_DIV_SHORTCUT_EN
    localparam int SC_LAT = 1;
`else
    localparam int SC_LAT = XLEN + 1;
`endif
    localparam int M_LAT = XLEN + 1;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [4:0]      alu_control;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_result;
    logic            zero;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    alu_mc #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .src_a       (src_a),
        .src_b       (src_b),
        .alu_control (alu_control),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_result  (alu_result),
        .zero        (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where
    // out_valid is first seen (or the cycle budget runs out).
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output logic z);
        check("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
        alu_control = op;
        src_a       = a;
        src_b       = b;
        in_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        src_a    = 32'hDEAD_BEEF;
        src_b    = 32'h1234_5678;
        lat      = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        res = alu_result;
        z   = zero;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [31:0] res;
        logic        z;
        logic        seen;

        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        src_a       = 32'd0;
        src_b       = 32'd0;
        alu_control = 5'd0;
        flush       = 1'b0;
        out_ready   = 1'b0;

        add_vec(5'b00000, 32'd5,          32'd7,          32'd12,         1);      // ADD
        add_vec(5'b00001, 32'd9,          32'd9,          32'd0,          1);      // SUB
        add_vec(5'b00010, 32'd1,          32'd35,         32'd8,          1);      // SLL
        add_vec(5'b00011, 32'hFFFF_FFFF,  32'd1,          32'd1,          1);      // SLT
        add_vec(5'b00100, 32'hFFFF_FFFF,  32'd1,          32'd0,          1);      // SLTU
        add_vec(5'b00101, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0,  1);      // XOR
        add_vec(5'b00110, 32'h8000_0000,  32'd4,          32'h0800_0000,  1);      // SRL
        add_vec(5'b00111, 32'h8000_0000,  32'd4,          32'hF800_0000,  1);      // SRA
        add_vec(5'b01000, 32'h0000_000F,  32'h0000_00F0,  32'h0000_00FF,  1);      // OR
        add_vec(5'b01001, 32'h0000_000F,  32'h0000_003C,  32'h0000_000C,  1);      // AND
        add_vec(5'b11111, 32'd5,          32'd7,          32'd0,          1);      // unknown
        add_vec(5'b01011, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  M_LAT);  // MULH
        add_vec(5'b01010, 32'hFFFF_FFFF,  32'd3,          32'hFFFF_FFFD,  M_LAT);  // MUL
        add_vec(5'b01010, 32'h0001_2345,  32'h0000_0100,  32'h0123_4500,  M_LAT);  // MUL
        add_vec(5'b01101, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  M_LAT);  // MULHU
        add_vec(5'b01100, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  M_LAT);  // MULHSU
        add_vec(5'b01011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          M_LAT);  // MULH
        add_vec(5'b01110, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  SC_LAT); // DIV ovf
        add_vec(5'b10000, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          SC_LAT); // REM ovf
        add_vec(5'b01110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  M_LAT);  // DIV -7/2
        add_vec(5'b10000, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  M_LAT);  // REM -7/2
        add_vec(5'b01111, 32'd7,          32'd0,          32'hFFFF_FFFF,  SC_LAT); // DIVU /0
        add_vec(5'b10001, 32'd7,          32'd0,          32'd7,          SC_LAT); // REMU /0
        add_vec(5'b01110, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  SC_LAT); // DIV -7/0
        add_vec(5'b10000, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  SC_LAT); // REM -7/0
        add_vec(5'b01111, 32'd100,        32'd7,          32'd14,         M_LAT);  // DIVU
        add_vec(5'b10001, 32'd100,        32'd7,          32'd2,          M_LAT);  // REMU

        // Reset values while rst_n is held low.
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result",    alu_result,         32'd0);
        check("rst_zero",      {31'd0, zero},      32'd1);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, lat, res, z);
            check($sformatf("vec%0d_result", i), res, vecs[i].res);
            check($sformatf("vec%0d_zero", i), {31'd0, z}, {31'd0, (vecs[i].res == 32'd0)});
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            pop();
        end

        // Result held while out_ready is low; a pending request waits for IDLE.
        issue(5'b00000, 32'd3, 32'd4, lat, res, z);
        check("hold_first_result", res, 32'd7);
        alu_control = 5'b00001;
        src_a       = 32'd10;
        src_b       = 32'd4;
        in_valid    = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_result",    alu_result,         32'd7);
            check("hold_in_ready",  {31'd0, in_ready},  32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("pop_in_ready",  {31'd0, in_ready},  32'd1);
        check("pop_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check("after_pop_valid",  {31'd0, out_valid}, 32'd1);
        check("after_pop_result", alu_result,         32'd6);
        pop();

        // Flush ten cycles into a divide.
        alu_control = 5'b01111;
        src_a       = 32'd100;
        src_b       = 32'd7;
        in_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("div_busy_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_in_ready",  {31'd0, in_ready},  32'd1);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("flush_no_result", {31'd0, seen}, 32'd0);

        // Reset pulsed in the middle of a multiply.
        issue(5'b00000, 32'd1, 32'd1, lat, res, z);
        check("pre_reset_result", res, 32'd2);
        pop();
        alu_control = 5'b01010;
        src_a       = 32'd3;
        src_b       = 32'd5;
        in_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_result",    alu_result,         32'd0);
        check("midrst_zero",      {31'd0, zero},      32'd1);
        check("midrst_in_ready",  {31'd0, in_ready},  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_result", {31'd0, seen}, 32'd0);
        issue(5'b01010, 32'd3, 32'd5, lat, res, z);
        check("post_reset_mul",     res, 32'd15);
        check("post_reset_latency", lat, M_LAT);
        pop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
